i2s_dma_ctrl: RTL and testbench

I2S_DMA_CTRL -- requirements
Module: i2s_dma_ctrl

---
 rtl/i2s_pkg.sv | 21 ++
 rtl/i2s_dma_addr_gen.sv | 82 ++++++++
 rtl/i2s_dma_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_i2s_dma_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive DMA controller.
//   state_e     : controller FSM state encoding
//   WORD_BYTES  : bytes per buffer word
//   word_addr() : byte address of a buffer word, wrapping modulo 2^32
package i2s_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + idx * WORD_BYTES;
  endfunction

endpackage

// File: rtl/i2s_dma_addr_gen.sv
// Buffer write-index and address generator.
//   clr      : restart the capture at word 0
//   adv      : a word was accepted by the bus; step to the next index
//   base     : captured buffer base byte address
//   words    : captured buffer length in words
//   wr_idx   : next buffer word index (held between captures)
//   m_addr   : byte address of wr_idx
//   last_hit : wr_idx is the final word of the buffer
//   half_irq : one-cycle pulse after the ack of the middle word
//   done_irq : one-cycle pulse after the ack of the final word
module i2s_dma_addr_gen
  import i2s_pkg::*;
#(
  parameter int BW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  input  logic [31:0]   base,
  input  logic [BW-1:0] words,
  output logic [BW-1:0] wr_idx,
  output logic [31:0]   m_addr,
  output logic          last_hit,
  output logic          half_irq,
  output logic          done_irq
);

  logic [BW-1:0] idx_q, idx_d;
  logic [31:0]   addr_q, addr_d;
  logic          half_q, half_d, done_q, done_d;
  logic          half_hit_s;

  // A one-word buffer has no meaningful midpoint, so the half pulse is suppressed there.
  assign half_hit_s = (words > BW'(1'b1)) && (idx_q == ((words >> 1) - BW'(1'b1)));
  assign last_hit   = (idx_q == (words - BW'(1'b1)));

  // Next index, address and interrupt pulses.
  always_comb begin
    idx_d  = idx_q;
    addr_d = addr_q;
    half_d = 1'b0;
    done_d = 1'b0;
    if (clr) begin
      idx_d  = {BW{1'b0}};
      addr_d = word_addr(base, 32'd0);
    end else if (adv) begin
      half_d = half_hit_s;
      done_d = last_hit;
      if (last_hit) begin
        idx_d = {BW{1'b0}};
      end else begin
        idx_d = idx_q + BW'(1'b1);
      end
      addr_d = word_addr(base, 32'(idx_d));
    end else begin
      idx_d  = idx_q;
      addr_d = addr_q;
    end
  end

  // Index, address and pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q  <= {BW{1'b0}};
      addr_q <= 32'd0;
      half_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      addr_q <= addr_d;
      half_q <= half_d;
      done_q <= done_d;
    end
  end

  assign wr_idx   = idx_q;
  assign m_addr   = addr_q;
  assign half_irq = half_q;
  assign done_irq = done_q;

endmodule

// File: rtl/i2s_dma_ctrl.sv
// I2S receive DMA controller: moves words from the receive FIFO into a
// memory buffer in bursts, one bus write per word.
//   control : start/stop pulses, circular mode, buffer base/length, burst size
//   fifo    : level/empty/full/head word in; pop, flush, receiver enable out
//   bus     : m_req/m_addr/m_wdata out, m_ack in
//   status  : busy, wr_idx, half/done pulses, sticky overrun
module i2s_dma_ctrl
  import i2s_pkg::*;
#(
  parameter int AW = 4,
  parameter int BW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          circular,
  input  logic [31:0]   buf_base,
  input  logic [BW-1:0] buf_words,
  input  logic [AW-1:0] burst_len,
  input  logic [AW-1:0] fifo_level,
  input  logic          fifo_empty,
  input  logic          fifo_full,
  input  logic [31:0]   fifo_rdata,
  output logic          fifo_rd,
  output logic          fifo_flush,
  output logic          i2s_en,
  output logic          m_req,
  output logic [31:0]   m_addr,
  output logic [31:0]   m_wdata,
  input  logic          m_ack,
  output logic          busy,
  output logic [BW-1:0] wr_idx,
  output logic          half_irq,
  output logic          done_irq,
  output logic          overrun
);

  state_e        state_q, state_d;
  logic [31:0]   base_q, base_d, wdata_q, wdata_d;
  logic [BW-1:0] words_q, words_d;
  logic [AW-1:0] burst_q, burst_d, cnt_q, cnt_d, bsz_s;
  logic          circ_q, circ_d, stop_pend_q, stop_pend_d;
  logic          ovr_q, ovr_d, flush_q, flush_d, en_q, en_d, req_q, req_d, busy_q, busy_d;
  logic          rd_s, clr_s, adv_s, last_s;

  // A programmed burst length of zero moves a single word.
  assign bsz_s = (burst_q == {AW{1'b0}}) ? AW'(1'b1) : burst_q;

  // Next-state, configuration capture, burst counting and output decode.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    words_d     = words_q;
    burst_d     = burst_q;
    circ_d      = circ_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    wdata_d     = wdata_q;
    rd_s        = 1'b0;
    clr_s       = 1'b0;
    adv_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stop_pend_d = 1'b0;
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start && (buf_words != {BW{1'b0}})) begin
          state_d = ST_FLUSH;
          base_d  = buf_base;
          words_d = buf_words;
          burst_d = burst_len;
          circ_d  = circular;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        clr_s   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if ((fifo_level >= bsz_s) || fifo_full) begin
          state_d = ST_READ;
          cnt_d   = bsz_s;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_READ: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (fifo_empty) begin
          state_d = ST_WAIT;
        end else begin
          rd_s    = 1'b1;
          wdata_d = fifo_rdata;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // A stop here cannot abort the bus cycle; it is held until the ack.
        stop_pend_d = stop_pend_q | stop;
        if (m_ack) begin
          adv_s = 1'b1;
          cnt_d = cnt_q - AW'(1'b1);
          if (stop_pend_q || stop) begin
            state_d = ST_IDLE;
          end else if (last_s) begin
            state_d = circ_q ? ST_WAIT : ST_IDLE;
          end else if (cnt_q == AW'(1'b1)) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_q == ST_FLUSH) begin
      ovr_d = 1'b0;
    end else if (fifo_full && en_q) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_q;
    end

    flush_d = (state_d == ST_FLUSH);
    en_d    = (state_d == ST_WAIT) || (state_d == ST_READ) || (state_d == ST_WRITE);
    req_d   = (state_d == ST_WRITE);
    busy_d  = (state_d != ST_IDLE);
  end

  // FSM state, captured configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= 32'd0;
      words_q     <= {BW{1'b0}};
      burst_q     <= {AW{1'b0}};
      circ_q      <= 1'b0;
      cnt_q       <= {AW{1'b0}};
      stop_pend_q <= 1'b0;
      wdata_q     <= 32'd0;
      ovr_q       <= 1'b0;
      flush_q     <= 1'b0;
      en_q        <= 1'b0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      words_q     <= words_d;
      burst_q     <= burst_d;
      circ_q      <= circ_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      wdata_q     <= wdata_d;
      ovr_q       <= ovr_d;
      flush_q     <= flush_d;
      en_q        <= en_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
    end
  end

  i2s_dma_addr_gen #(.BW(BW)) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_s),
    .adv      (adv_s),
    .base     (base_q),
    .words    (words_q),
    .wr_idx   (wr_idx),
    .m_addr   (m_addr),
    .last_hit (last_s),
    .half_irq (half_irq),
    .done_irq (done_irq)
  );

  // The pop must follow the FIFO's empty flag in the same cycle, so it is decoded directly.
  assign fifo_rd    = rd_s;
  assign fifo_flush = flush_q;
  assign i2s_en     = en_q;
  assign m_req      = req_q;
  assign m_wdata    = wdata_q;
  assign busy       = busy_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_i2s_dma_ctrl.sv
// Self-checking bench for i2s_dma_ctrl: a queue-based FIFO source, a bus
// responder with programmable ack latency, and expectations computed from
// buffer arithmetic (address = base + 4*(k mod words), data in arrival order).
module tb_i2s_dma_ctrl;
  localparam int AW = 4;
  localparam int BW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, stop, circular;
  logic [31:0]   buf_base;
  logic [BW-1:0] buf_words;
  logic [AW-1:0] burst_len;
  logic [AW-1:0] fifo_level;
  logic          fifo_empty, fifo_full;
  logic [31:0]   fifo_rdata;
  logic          fifo_rd, fifo_flush, i2s_en;
  logic          m_req, m_ack;
  logic [31:0]   m_addr, m_wdata;
  logic          busy, half_irq, done_irq, overrun;
  logic [BW-1:0] wr_idx;

  i2s_dma_ctrl #(.AW(AW), .BW(BW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .circular(circular),
    .buf_base(buf_base), .buf_words(buf_words), .burst_len(burst_len),
    .fifo_level(fifo_level), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd), .fifo_flush(fifo_flush), .i2s_en(i2s_en),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(m_ack),
    .busy(busy), .wr_idx(wr_idx), .half_irq(half_irq), .done_irq(done_irq), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] fifo_q[$], feed_q[$], src_q[$], wr_addr_q[$], wr_data_q[$];
  logic rd_seen, flush_seen, en_seen, rst_v, force_full;
  int ack_delay, req_age, pops, half_n, done_n, half_at, done_at;
  logic [31:0] w0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply the effects of the edge, drive inputs, sample at the falling edge.
  task automatic cyc(input logic st, input logic sp);
    @(posedge clk);
    #1;
    if (rd_seen) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pops++;
    end
    if (flush_seen) fifo_q.delete();
    if (en_seen && feed_q.size() > 0 && fifo_q.size() < 15) fifo_q.push_back(feed_q.pop_front());
    start = st;
    stop  = sp;
    rst_n = rst_v;
    if (m_req) begin
      m_ack   = (req_age == ack_delay);
      req_age = m_ack ? 0 : req_age + 1;
    end else begin
      m_ack   = 1'b0;
      req_age = 0;
    end
    fifo_level = AW'(fifo_q.size());
    fifo_empty = (fifo_q.size() == 0);
    fifo_full  = force_full || (fifo_q.size() == 15);
    fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
    @(negedge clk);
    rd_seen    = fifo_rd;
    flush_seen = fifo_flush;
    en_seen    = i2s_en;
    if (m_req && m_ack) begin
      wr_addr_q.push_back(m_addr);
      wr_data_q.push_back(m_wdata);
    end
    if (half_irq) begin half_n++; half_at = wr_addr_q.size(); end
    if (done_irq) begin done_n++; done_at = wr_addr_q.size(); end
  endtask

  task automatic clear_logs();
    feed_q.delete(); src_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    pops = 0; half_n = 0; done_n = 0; half_at = -1; done_at = -1;
  endtask

  task automatic feed(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      feed_q.push_back(w);
      src_q.push_back(w);
    end
  endtask

  task automatic run_until_idle(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      cyc(1'b0, 1'b0);
      if (!busy) break;
    end
    chk({tag, " finished"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_req(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (m_req) break;
      cyc(1'b0, 1'b0);
    end
    chk({tag, " req seen"}, 32'(m_req), 32'd1);
  endtask

  task automatic check_writes(input string tag, input logic [31:0] base, input int words, input int n);
    chk({tag, " count"}, 32'(wr_addr_q.size()), 32'(n));
    for (int k = 0; k < n && k < wr_addr_q.size(); k++) begin
      chk($sformatf("%s addr%0d", tag, k), wr_addr_q[k], base + 32'(4 * (k % words)));
      chk($sformatf("%s data%0d", tag, k), wr_data_q[k], src_q[k]);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " m_req"}, 32'(m_req), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " i2s_en"}, 32'(i2s_en), 32'd0);
    chk({tag, " fifo_rd"}, 32'(fifo_rd), 32'd0);
    chk({tag, " fifo_flush"}, 32'(fifo_flush), 32'd0);
    chk({tag, " half_irq"}, 32'(half_irq), 32'd0);
    chk({tag, " done_irq"}, 32'(done_irq), 32'd0);
    chk({tag, " overrun"}, 32'(overrun), 32'd0);
    chk({tag, " wr_idx"}, 32'(wr_idx), 32'd0);
    chk({tag, " m_addr"}, m_addr, 32'd0);
    chk({tag, " m_wdata"}, m_wdata, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; rst_v = 1'b0; start = 1'b0; stop = 1'b0; circular = 1'b0;
    buf_base = 32'd0; buf_words = 16'd0; burst_len = 4'd0;
    fifo_level = 4'd0; fifo_empty = 1'b1; fifo_full = 1'b0; fifo_rdata = 32'd0;
    m_ack = 1'b0; force_full = 1'b0; ack_delay = 1; req_age = 0;
    rd_seen = 1'b0; flush_seen = 1'b0; en_seen = 1'b0;
    clear_logs();

    // Reset state
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check_zero("reset");
    rst_v = 1'b1;
    cyc(1'b0, 1'b0);

    // Linear capture, burst 2, ack one cycle after request; config changes after start ignored
    clear_logs();
    buf_base = 32'h1000; buf_words = 16'd4; burst_len = 4'd2; circular = 1'b0; ack_delay = 1;
    feed(4);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("s1 flush", 32'(fifo_flush), 32'd1);
    chk("s1 en in flush", 32'(i2s_en), 32'd0);
    buf_base = 32'h8000; buf_words = 16'd9; burst_len = 4'd7; circular = 1'b1;
    run_until_idle("s1", 200);
    check_writes("s1", 32'h1000, 4, 4);
    chk("s1 half count", 32'(half_n), 32'd1);
    chk("s1 half after ack", 32'(half_at), 32'd2);
    chk("s1 done count", 32'(done_n), 32'd1);
    chk("s1 done after ack", 32'(done_at), 32'd4);
    chk("s1 i2s_en", 32'(i2s_en), 32'd0);
    chk("s1 wr_idx", 32'(wr_idx), 32'd0);

    // Circular capture across the 2^32 address wrap, burst_len 0 means one word
    clear_logs();
    buf_base = 32'hFFFF_FFF8; buf_words = 16'd3; burst_len = 4'd0; circular = 1'b1; ack_delay = 0;
    feed(7);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      if (wr_addr_q.size() >= 7) break;
      cyc(1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    check_writes("s2", 32'hFFFF_FFF8, 3, 7);
    chk("s2 done count", 32'(done_n), 32'd2);
    chk("s2 half count", 32'(half_n), 32'd3);
    chk("s2 wr_idx", 32'(wr_idx), 32'd1);
    chk("s2 still busy", 32'(busy), 32'd1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk("s2 stop in wait", 32'(busy), 32'd0);
    chk("s2 wr_idx held", 32'(wr_idx), 32'd1);

    // Slow ack with stop during WRITE
    clear_logs();
    buf_base = 32'h2000; buf_words = 16'd8; burst_len = 4'd4; circular = 1'b0; ack_delay = 5;
    feed(4);
    cyc(1'b1, 1'b0);
    wait_req("s3", 100);
    w0 = m_wdata;
    chk("s3 addr", m_addr, 32'h2000);
    chk("s3 first data", w0, src_q[0]);
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("s3 req held", 32'(m_req), 32'd1);
      chk("s3 wdata stable", m_wdata, w0);
      if (wr_addr_q.size() != 0) break;
      cyc(1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0);
    chk("s3 idle after ack", 32'(busy), 32'd0);
    cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    check_writes("s3", 32'h2000, 8, 1);
    chk("s3 pops", 32'(pops), 32'd1);
    chk("s3 i2s_en", 32'(i2s_en), 32'd0);

    // Overrun is sticky, survives an ignored start and a stop, clears in FLUSH
    clear_logs();
    buf_base = 32'h3000; buf_words = 16'd8; burst_len = 4'd4; circular = 1'b0; ack_delay = 1;
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    chk("s4 overrun clear", 32'(overrun), 32'd0);
    force_full = 1'b1;
    cyc(1'b0, 1'b0);
    force_full = 1'b0;
    cyc(1'b0, 1'b0);
    chk("s4 overrun set", 32'(overrun), 32'd1);
    cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    chk("s4 overrun sticky", 32'(overrun), 32'd1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("s4 busy start ignored", 32'(busy), 32'd1);
    chk("s4 no reflush", 32'(fifo_flush), 32'd0);
    chk("s4 overrun kept", 32'(overrun), 32'd1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk("s4 stopped", 32'(busy), 32'd0);
    chk("s4 overrun after stop", 32'(overrun), 32'd1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("s4 flush", 32'(fifo_flush), 32'd1);
    chk("s4 en in flush", 32'(i2s_en), 32'd0);
    cyc(1'b0, 1'b0);
    chk("s4 overrun cleared", 32'(overrun), 32'd0);
    chk("s4 en in wait", 32'(i2s_en), 32'd1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk("s4 end idle", 32'(busy), 32'd0);

    // Zero-length start, and start+stop together, are both ignored
    clear_logs();
    buf_words = 16'd0;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("s5 zero busy", 32'(busy), 32'd0);
    chk("s5 zero flush", 32'(fifo_flush), 32'd0);
    cyc(1'b0, 1'b0);
    chk("s5 zero req", 32'(m_req), 32'd0);
    buf_words = 16'd4;
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    chk("s5 stop wins", 32'(busy), 32'd0);
    chk("s5 stop wins flush", 32'(fifo_flush), 32'd0);
    chk("s5 writes", 32'(wr_addr_q.size()), 32'd0);

    // Reset in the middle of a bus write
    clear_logs();
    buf_base = 32'h4000; buf_words = 16'd8; burst_len = 4'd1; circular = 1'b0; ack_delay = 10;
    feed(2);
    cyc(1'b1, 1'b0);
    wait_req("s6", 100);
    rst_v = 1'b0;
    cyc(1'b0, 1'b0);
    chk("s6 req before edge", 32'(m_req), 32'd1);
    cyc(1'b0, 1'b0);
    check_zero("s6");
    rst_v = 1'b1;
    cyc(1'b0, 1'b0);

    // Randomized linear captures against the buffer model
    for (int it = 0; it < 3; it++) begin
      int w;
      int b;
      int bsz;
      logic [31:0] base;
      clear_logs();
      w    = $urandom_range(2, 7);
      b    = $urandom_range(0, w);
      bsz  = (b == 0) ? 1 : b;
      base = $urandom & 32'hFFFF_FFFC;
      buf_base = base; buf_words = BW'(w); burst_len = AW'(b); circular = 1'b0;
      ack_delay = $urandom_range(0, 3);
      feed(w + bsz);
      cyc(1'b1, 1'b0);
      run_until_idle("s7", 400);
      check_writes("s7", base, w, w);
      chk("s7 half count", 32'(half_n), 32'd1);
      chk("s7 done count", 32'(done_n), 32'd1);
      chk("s7 wr_idx", 32'(wr_idx), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
